// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/multi-cycle producers and the regfile arbiter.
// The slave side is the arbiter and the master side is the producers plus the regfile.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [31:0] b_pending_mask;

  modport slave (
    input  a_valid, a_reg, a_data,
    input  b_valid, b_reg, b_data,
    output a_ready, b_ready,
    output RegWrite, WriteRegister, WriteData,
    output b_pending_mask
  );

  modport master (
    output a_valid, a_reg, a_data,
    output b_valid, b_reg, b_data,
    input  a_ready, b_ready,
    input  RegWrite, WriteRegister, WriteData,
    input  b_pending_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single-port regfile writeback arbiter: unbuffered ALU path, 2-deep
// multi-cycle FIFO, starvation guard and a pending-destination mask.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t           fifo_q [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic [1:0]    count_nx;
  logic [SW-1:0] starve_cnt;

  logic          not_empty;
  logic          force_b;
  logic          grant_a;
  logic          grant_b;
  logic          enq;
  wb_t           win;
  logic          slot0_vld;
  logic          slot1_vld;
  logic [31:0]   mask;

  always_comb begin
    not_empty = (count != 2'd0);
    force_b   = not_empty && (starve_cnt == LIMIT);
    grant_a   = !force_b && bus.a_valid;
    grant_b   = force_b || (!bus.a_valid && not_empty);
    enq       = bus.b_valid && (count < 2'd2);
    win       = '{rd: bus.a_reg, data: bus.a_data};
    if (grant_b)
      win = fifo_q[rd_ptr];
  end

  always_comb begin
    count_nx = count;
    unique case ({enq, grant_b})
      2'b10:   count_nx = count + 2'd1;
      2'b01:   count_nx = count - 2'd1;
      default: count_nx = count;
    endcase
  end

  // A slot holds a live entry if the FIFO is full or it is the sole head.
  always_comb begin
    slot0_vld = (count == 2'd2) || (count == 2'd1 && !rd_ptr);
    slot1_vld = (count == 2'd2) || (count == 2'd1 && rd_ptr);
    mask      = '0;
    if (slot0_vld)
      mask[fifo_q[0].rd] = 1'b1;
    if (slot1_vld)
      mask[fifo_q[1].rd] = 1'b1;
    mask[0] = 1'b0;
  end

  assign bus.a_ready        = !force_b;
  assign bus.b_ready        = (count < 2'd2);
  assign bus.b_pending_mask = mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0]         <= '0;
      fifo_q[1]         <= '0;
      rd_ptr            <= 1'b0;
      wr_ptr            <= 1'b0;
      count             <= 2'd0;
      starve_cnt        <= '0;
      bus.RegWrite      <= 1'b0;
      bus.WriteRegister <= '0;
      bus.WriteData     <= '0;
    end else begin
      if (enq) begin
        fifo_q[wr_ptr] <= '{rd: bus.b_reg, data: bus.b_data};
        wr_ptr         <= ~wr_ptr;
      end
      if (grant_b)
        rd_ptr <= ~rd_ptr;
      count <= count_nx;

      if (grant_b || !not_empty)
        starve_cnt <= '0;
      else if (grant_a && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 1'b1;

      // Register 0 grants still retire but never reach the regfile.
      bus.RegWrite <= (grant_a || grant_b) && (win.rd != 5'd0);
      if (grant_a || grant_b) begin
        bus.WriteRegister <= win.rd;
        bus.WriteData     <= win.data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed cycle tables drive
// both producers while a monitor retires expected writes in order.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst_n;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [36:0] exp_q [$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && bus.RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexp_wr", 32'(bus.RegWrite), 32'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wr_reg", 32'(bus.WriteRegister), 32'(e[36:32]));
        check("wr_data", bus.WriteData, e[31:0]);
      end
    end
  end

  task automatic cyc(input logic        av,
                     input logic [4:0]  ar,
                     input logic [31:0] ad,
                     input logic        bv,
                     input logic [4:0]  br,
                     input logic [31:0] bd,
                     input logic        e_ardy,
                     input logic        e_brdy,
                     input logic [31:0] e_mask);
    bus.a_valid = av;
    bus.a_reg   = ar;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_reg   = br;
    bus.b_data  = bd;
    check("a_ready", 32'(bus.a_ready), 32'(e_ardy));
    check("b_ready", 32'(bus.b_ready), 32'(e_brdy));
    check("mask", bus.b_pending_mask, e_mask);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] e_mask);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, e_mask);
  endtask

  function automatic logic [31:0] adat(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] bit_of(input int n);
    logic [31:0] m;
    m = '0;
    m[n] = 1'b1;
    return m;
  endfunction

  logic [31:0] m3, m10, m11, m12, m13;

  initial begin
    m3  = bit_of(3);
    m10 = bit_of(10);
    m11 = bit_of(11);
    m12 = bit_of(12);
    m13 = bit_of(13);

    rst_n       = 1'b0;
    bus.a_valid = 1'b0;
    bus.a_reg   = '0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_reg   = '0;
    bus.b_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(bus.RegWrite), 32'd0);
    check("rst_wreg", 32'(bus.WriteRegister), 32'd0);
    check("rst_wdata", bus.WriteData, 32'd0);
    check("rst_mask", bus.b_pending_mask, 32'd0);
    check("rst_brdy", 32'(bus.b_ready), 32'd1);
    check("rst_ardy", 32'(bus.a_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // A only
    push(5, 32'hDEAD_BEEF);
    cyc(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 1, 1, 0);
    check("a_lat", 32'(bus.RegWrite), 32'd1);
    idle(0);
    check("idle_we", 32'(bus.RegWrite), 32'd0);
    check("hold_reg", 32'(bus.WriteRegister), 32'd5);
    check("hold_data", bus.WriteData, 32'hDEAD_BEEF);
    check("drain_a", 32'(exp_q.size()), 32'd0);

    // B only
    push(8, 32'h1234_5678);
    cyc(0, 0, 0, 1, 8, 32'h1234_5678, 1, 1, 0);
    check("b_lat1", 32'(bus.RegWrite), 32'd0);
    idle(32'h0000_0100);
    check("b_lat2", 32'(bus.RegWrite), 32'd1);
    check("b_mask0", bus.b_pending_mask, 32'd0);
    idle(0);
    check("drain_b", 32'(exp_q.size()), 32'd0);

    // Zero register on both paths
    cyc(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 1, 0);
    check("a_zero_we", 32'(bus.RegWrite), 32'd0);
    cyc(0, 0, 0, 1, 0, 32'h5555_5555, 1, 1, 0);
    idle(0);
    check("b_zero_we", 32'(bus.RegWrite), 32'd0);
    idle(0);
    check("b_zero_gone", 32'(bus.b_ready), 32'd1);

    // Simultaneous enqueue and dequeue at count 1
    push(1, 32'hB000_0001);
    push(2, 32'hB000_0002);
    cyc(0, 0, 0, 1, 1, 32'hB000_0001, 1, 1, 0);
    cyc(0, 0, 0, 1, 2, 32'hB000_0002, 1, 1, bit_of(1));
    idle(bit_of(2));
    idle(0);
    check("drain_fifo", 32'(exp_q.size()), 32'd0);

    // Starvation: one B entry, ALU never idle
    for (int i = 20; i < 25; i++) push(5'(i), adat(i));
    push(3, 32'hB000_0003);
    push(25, adat(25));
    cyc(1, 20, adat(20), 1, 3, 32'hB000_0003, 1, 1, 0);
    cyc(1, 21, adat(21), 0, 0, 0, 1, 1, m3);
    cyc(1, 22, adat(22), 0, 0, 0, 1, 1, m3);
    cyc(1, 23, adat(23), 0, 0, 0, 1, 1, m3);
    cyc(1, 24, adat(24), 0, 0, 0, 1, 1, m3);
    cyc(1, 25, adat(25), 0, 0, 0, 0, 1, m3);
    cyc(1, 25, adat(25), 0, 0, 0, 1, 1, 0);
    idle(0);
    check("drain_starve", 32'(exp_q.size()), 32'd0);

    // Full FIFO back-pressure, ordering 10, 11, 12
    for (int i = 0; i < 5; i++) push(5'(16 + i), adat(i));
    push(10, 32'hB000_000A);
    for (int i = 5; i < 9; i++) push(5'(16 + i), adat(i));
    push(11, 32'hB000_000B);
    push(12, 32'hB000_000C);
    cyc(1, 16, adat(0), 1, 10, 32'hB000_000A, 1, 1, 0);
    cyc(1, 17, adat(1), 1, 11, 32'hB000_000B, 1, 1, m10);
    cyc(1, 18, adat(2), 1, 12, 32'hB000_000C, 1, 0, m10 | m11);
    cyc(1, 19, adat(3), 1, 12, 32'hB000_000C, 1, 0, m10 | m11);
    cyc(1, 20, adat(4), 1, 12, 32'hB000_000C, 1, 0, m10 | m11);
    cyc(1, 21, adat(5), 1, 12, 32'hB000_000C, 0, 0, m10 | m11);
    cyc(1, 21, adat(5), 1, 12, 32'hB000_000C, 1, 1, m11);
    cyc(1, 22, adat(6), 0, 0, 0, 1, 0, m11 | m12);
    cyc(1, 23, adat(7), 0, 0, 0, 1, 0, m11 | m12);
    cyc(1, 24, adat(8), 0, 0, 0, 1, 0, m11 | m12);
    cyc(1, 25, adat(9), 0, 0, 0, 0, 0, m11 | m12);
    idle(m12);
    idle(0);
    check("drain_full", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation with a full FIFO and a write in flight
    push(26, adat(30));
    push(27, adat(31));
    cyc(1, 26, adat(30), 1, 13, 32'hD000_000D, 1, 1, 0);
    cyc(1, 27, adat(31), 1, 14, 32'hD000_000E, 1, 1, m13);
    check("pre_rst_we", 32'(bus.RegWrite), 32'd1);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(bus.RegWrite), 32'd0);
    check("mid_rst_wreg", 32'(bus.WriteRegister), 32'd0);
    check("mid_rst_wdata", bus.WriteData, 32'd0);
    check("mid_rst_mask", bus.b_pending_mask, 32'd0);
    check("mid_rst_brdy", 32'(bus.b_ready), 32'd1);
    check("mid_rst_ardy", 32'(bus.a_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) idle(0);
    check("post_rst_we", 32'(bus.RegWrite), 32'd0);
    check("drain_rst", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
